// File: rtl/decode_stage.sv
// decode_stage: one-entry registered RV64 integer decode stage.
// Decodes OP-IMM, OP, OP-IMM-32 and OP-32 (including the M extension) into an ALU
// control code, register indices and an immediate. Any other encoding is flagged illegal
// but still travels down the pipe and is counted like any other instruction.
// The stage holds one bundle. Its handshake is valid/ready on both sides.
//
// Ports:
//   clk             - clock; every state update happens on its rising edge
//   reset_n         - asynchronous active-low reset
//   flush           - drops the held bundle and blocks the incoming one
//   in_valid        - fetch is presenting an instruction
//   in_ready        - the stage takes the instruction this cycle
//   in_instr        - raw 32-bit instruction
//   in_pc           - address of the instruction
//   out_valid       - the decoded bundle is valid
//   out_ready       - execute consumes the bundle
//   out_alu_control - ALU operation code (0 when illegal)
//   out_rs1/rs2/rd  - register indices
//   out_imm         - immediate operand used as dataB when out_use_imm=1
//   out_use_imm     - selects out_imm instead of rs2 for dataB
//   out_illegal     - the instruction is outside the supported set
//   out_pc          - registered pc
//   out_count       - number of accepted instructions; wraps modulo 2^32
module decode_stage #(
  parameter int unsigned BUS_DATA_WIDTH = 64
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               in_instr,
  input  logic [BUS_DATA_WIDTH-1:0] in_pc,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [5:0]                out_alu_control,
  output logic [4:0]                out_rs1,
  output logic [4:0]                out_rs2,
  output logic [4:0]                out_rd,
  output logic [BUS_DATA_WIDTH-1:0] out_imm,
  output logic                      out_use_imm,
  output logic                      out_illegal,
  output logic [BUS_DATA_WIDTH-1:0] out_pc,
  output logic [31:0]               out_count
);

  localparam logic [6:0] OpImm   = 7'b0010011;
  localparam logic [6:0] OpReg   = 7'b0110011;
  localparam logic [6:0] OpImm32 = 7'b0011011;
  localparam logic [6:0] OpReg32 = 7'b0111011;

  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;
  localparam logic [6:0] F7Mul  = 7'b0000001;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  logic [BUS_DATA_WIDTH-1:0] immI;
  logic [BUS_DATA_WIDTH-1:0] immSh64;
  logic [BUS_DATA_WIDTH-1:0] immSh32;

  assign immI    = {{(BUS_DATA_WIDTH-12){in_instr[31]}}, in_instr[31:20]};
  assign immSh64 = {{(BUS_DATA_WIDTH-6){1'b0}}, in_instr[25:20]};
  assign immSh32 = {{(BUS_DATA_WIDTH-5){1'b0}}, in_instr[24:20]};

  logic [5:0]                decAlu;
  logic [4:0]                decRs2;
  logic [BUS_DATA_WIDTH-1:0] decImm;
  logic                      decUseImm;
  logic                      decIllegal;

  always_comb begin
    decAlu     = 6'd0;
    decRs2     = in_instr[24:20];
    decImm     = '0;
    decUseImm  = 1'b0;
    decIllegal = 1'b0;

    case (opcode)
      OpImm: begin
        decUseImm = 1'b1;
        decRs2    = 5'd0;
        decImm    = immI;
        case (funct3)
          3'b000: decAlu = 6'd1;
          3'b010: decAlu = 6'd2;
          3'b011: decAlu = 6'd3;
          3'b100: decAlu = 6'd4;
          3'b110: decAlu = 6'd5;
          3'b111: decAlu = 6'd6;
          3'b001: begin
            decImm = immSh64;
            if (in_instr[31:26] == 6'b000000) decAlu = 6'd7;
            else                              decIllegal = 1'b1;
          end
          default: begin // 3'b101
            decImm = immSh64;
            if (in_instr[31:26] == 6'b000000)      decAlu = 6'd8;
            else if (in_instr[31:26] == 6'b010000) decAlu = 6'd9;
            else                                   decIllegal = 1'b1;
          end
        endcase
      end

      OpImm32: begin
        decUseImm = 1'b1;
        decRs2    = 5'd0;
        decImm    = immSh32;
        case (funct3)
          3'b000: begin
            decImm = immI;
            decAlu = 6'd22;
          end
          3'b001: begin
            if (funct7 == F7Base) decAlu = 6'd23;
            else                  decIllegal = 1'b1;
          end
          3'b101: begin
            if (funct7 == F7Base)     decAlu = 6'd24;
            else if (funct7 == F7Alt) decAlu = 6'd25;
            else                      decIllegal = 1'b1;
          end
          default: decIllegal = 1'b1;
        endcase
      end

      OpReg: begin
        if (funct7 == F7Base) begin
          case (funct3)
            3'b000: decAlu = 6'd12;
            3'b001: decAlu = 6'd14;
            3'b010: decAlu = 6'd15;
            3'b011: decAlu = 6'd16;
            3'b100: decAlu = 6'd17;
            3'b101: decAlu = 6'd18;
            3'b110: decAlu = 6'd20;
            default: decAlu = 6'd21;
          endcase
        end else if (funct7 == F7Alt) begin
          if (funct3 == 3'b000)      decAlu = 6'd13;
          else if (funct3 == 3'b101) decAlu = 6'd19;
          else                       decIllegal = 1'b1;
        end else if (funct7 == F7Mul) begin
          // mul..remu are numbered consecutively in funct3 order.
          decAlu = 6'd31 + {3'b000, funct3};
        end else begin
          decIllegal = 1'b1;
        end
      end

      OpReg32: begin
        if (funct7 == F7Base) begin
          if (funct3 == 3'b000)      decAlu = 6'd26;
          else if (funct3 == 3'b001) decAlu = 6'd28;
          else if (funct3 == 3'b101) decAlu = 6'd29;
          else                       decIllegal = 1'b1;
        end else if (funct7 == F7Alt) begin
          if (funct3 == 3'b000)      decAlu = 6'd27;
          else if (funct3 == 3'b101) decAlu = 6'd30;
          else                       decIllegal = 1'b1;
        end else if (funct7 == F7Mul) begin
          case (funct3)
            3'b000: decAlu = 6'd39;
            3'b100: decAlu = 6'd40;
            3'b101: decAlu = 6'd41;
            3'b110: decAlu = 6'd42;
            3'b111: decAlu = 6'd43;
            default: decIllegal = 1'b1;
          endcase
        end else begin
          decIllegal = 1'b1;
        end
      end

      default: decIllegal = 1'b1;
    endcase

    // An illegal instruction carries no operation and no immediate.
    if (decIllegal) begin
      decAlu    = 6'd0;
      decUseImm = 1'b0;
      decImm    = '0;
    end
  end

  logic validQ;
  logic accept;

  assign in_ready = !validQ || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  logic [5:0]                aluQ;
  logic [4:0]                rs1Q;
  logic [4:0]                rs2Q;
  logic [4:0]                rdQ;
  logic [BUS_DATA_WIDTH-1:0] immQ;
  logic                      useImmQ;
  logic                      illegalQ;
  logic [BUS_DATA_WIDTH-1:0] pcQ;
  logic [31:0]               countQ;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      validQ   <= 1'b0;
      aluQ     <= '0;
      rs1Q     <= '0;
      rs2Q     <= '0;
      rdQ      <= '0;
      immQ     <= '0;
      useImmQ  <= 1'b0;
      illegalQ <= 1'b0;
      pcQ      <= '0;
      countQ   <= '0;
    end else if (flush) begin
      validQ <= 1'b0;
    end else if (accept) begin
      // Covers both an empty stage and a consume-and-reload in the same cycle.
      validQ   <= 1'b1;
      aluQ     <= decAlu;
      rs1Q     <= in_instr[19:15];
      rs2Q     <= decRs2;
      rdQ      <= in_instr[11:7];
      immQ     <= decImm;
      useImmQ  <= decUseImm;
      illegalQ <= decIllegal;
      pcQ      <= in_pc;
      countQ   <= countQ + 32'd1;
    end else if (out_ready) begin
      validQ <= 1'b0;
    end
  end

  assign out_valid       = validQ;
  assign out_alu_control = aluQ;
  assign out_rs1         = rs1Q;
  assign out_rs2         = rs2Q;
  assign out_rd          = rdQ;
  assign out_imm         = immQ;
  assign out_use_imm     = useImmQ;
  assign out_illegal     = illegalQ;
  assign out_pc          = pcQ;
  assign out_count       = countQ;

endmodule
